// File: rtl/mux_arb_8.sv
// Round-robin arbiter owning the select of an N:1 data mux, presenting the chosen word on a valid/ready channel.
// Optional `MUX_ARB_LOCK_EN adds lock_i for multi-word bursts that hold the grant across transfers.
module mux_arb_8 #(
    parameter  int N  = 8,
    parameter  int DW = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    input  logic [N*DW-1:0] a_i,
`ifdef MUX_ARB_LOCK_EN
    input  logic [N-1:0]    lock_i,
`endif
    input  logic            ready_i,
    output logic            valid_o,
    output logic [DW-1:0]   y_o,
    output logic [SW-1:0]   s_o,
    output logic [N-1:0]    ack_o,
    output logic            busy_o
);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_sel, w_sel_nxt;
    logic [SW-1:0] r_ptr, w_ptr_nxt, w_ptr_adv;
    logic [N-1:0]  w_masked;
    logic          w_busy, w_valid, w_xfer, w_lock;
    logic [DW-1:0] w_y;
    logic [N-1:0]  w_ack;

    // First set request scanning from ptr upward, wrapping modulo N.
    function automatic logic [SW-1:0] f_arb(input logic [N-1:0] req, input logic [SW-1:0] ptr);
        logic [SW-1:0] win;
        logic [SW-1:0] k;
        logic          found;
        int unsigned   idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            k   = SW'(idx);
            if (!found && req[k]) begin
                win   = k;
                found = 1'b1;
            end
        end
        return win;
    endfunction

`ifdef MUX_ARB_LOCK_EN
    assign w_lock = lock_i[r_sel];
`else
    assign w_lock = 1'b0;
`endif

    assign w_busy    = (r_state == ST_GRANT);
    assign w_valid   = w_busy && req_i[r_sel];
    assign w_xfer    = w_valid && ready_i;
    assign w_ptr_adv = (r_sel == SW'(N - 1)) ? '0 : r_sel + 1'b1;

    always_comb begin
        w_y = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (SW'(k) == r_sel) w_y = a_i[k*DW +: DW];
        end
    end

    always_comb begin
        w_ack = '0;
        if (w_xfer) w_ack[r_sel] = 1'b1;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_ptr_nxt       = r_ptr;
        w_masked        = req_i;
        w_masked[r_sel] = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_i) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = f_arb(req_i, r_ptr);
                end
            end
            ST_GRANT: begin
                if (!w_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_xfer && !w_lock) begin
                    // Re-arbitrate in the transfer cycle so back-to-back grants need no idle cycle.
                    w_ptr_nxt = w_ptr_adv;
                    if (|w_masked) w_sel_nxt = f_arb(w_masked, w_ptr_adv);
                    else           w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign valid_o = w_valid;
    assign y_o     = w_y;
    assign s_o     = r_sel;
    assign ack_o   = w_ack;
    assign busy_o  = w_busy;

endmodule

// File: tb/tb_mux_arb_8.sv
// Testbench for mux_arb_8: directed vector table, hand sequences, and randomized traffic vs a reference model.
module tb_mux_arb_8;
    localparam int N  = 8;
    localparam int DW = 8;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req   = '0;
    logic [N*DW-1:0] a     = '0;
    logic            ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    logic [N-1:0]    lock  = '0;
`endif
    logic            valid;
    logic [DW-1:0]   y;
    logic [2:0]      s;
    logic [N-1:0]    ack;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    int m_busy, m_sel, m_ptr;

    always #5 clk = ~clk;

    mux_arb_8 #(.N(N), .DW(DW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .a_i     (a),
`ifdef MUX_ARB_LOCK_EN
        .lock_i  (lock),
`endif
        .ready_i (ready),
        .valid_o (valid),
        .y_o     (y),
        .s_o     (s),
        .ack_o   (ack),
        .busy_o  (busy)
    );

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       ev;
        logic [7:0] eack;
        logic [2:0] es;
        logic       eb;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic m_valid();
        return (m_busy != 0) && req[m_sel];
    endfunction

    function automatic logic [N-1:0] m_ack();
        logic [N-1:0] v;
        v = '0;
        if (m_valid() && ready) v[m_sel] = 1'b1;
        return v;
    endfunction

    task automatic m_reset();
        m_busy = 0;
        m_sel  = 0;
        m_ptr  = 0;
    endtask

    task automatic check_model();
        chk("valid", valid, m_valid());
        chk("ack",   ack,   m_ack());
        chk("sel",   s,     m_sel);
        chk("y",     y,     a[m_sel*DW +: DW]);
        chk("busy",  busy,  m_busy);
    endtask

    task automatic model_update();
        logic [N-1:0] masked;
        logic         locked;
        locked = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        locked = lock[m_sel];
`endif
        if (m_busy == 0) begin
            if (req != 0) begin
                m_sel  = winner(req, m_ptr);
                m_busy = 1;
            end
        end else if (!req[m_sel]) begin
            m_busy = 0;
        end else if (ready && !locked) begin
            m_ptr  = (m_sel + 1) % N;
            masked = req;
            masked[m_sel] = 1'b0;
            if (masked != 0) m_sel = winner(masked, m_ptr);
            else             m_busy = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        lock  = '0;
`endif
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) a[k*DW +: DW] = 8'hA3 + 8'(k);

        tbl[0]  = '{8'h04, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{8'h04, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1};
        tbl[2]  = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0};
        tbl[3]  = '{8'h20, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0};
        tbl[4]  = '{8'hFF, 1'b0, 1'b1, 8'h00, 3'd5, 1'b1};
        tbl[5]  = '{8'hFF, 1'b0, 1'b1, 8'h00, 3'd5, 1'b1};
        tbl[6]  = '{8'hFF, 1'b0, 1'b1, 8'h00, 3'd5, 1'b1};
        tbl[7]  = '{8'hFF, 1'b1, 1'b1, 8'h20, 3'd5, 1'b1};
        tbl[8]  = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd6, 1'b1};
        tbl[9]  = '{8'h40, 1'b1, 1'b0, 8'h00, 3'd6, 1'b0};
        tbl[10] = '{8'h40, 1'b1, 1'b1, 8'h40, 3'd6, 1'b1};
        tbl[11] = '{8'h81, 1'b0, 1'b0, 8'h00, 3'd6, 1'b0};
        tbl[12] = '{8'h01, 1'b0, 1'b0, 8'h00, 3'd7, 1'b1};
        tbl[13] = '{8'h81, 1'b0, 1'b0, 8'h00, 3'd7, 1'b0};
        tbl[14] = '{8'h81, 1'b1, 1'b1, 8'h80, 3'd7, 1'b1};
        tbl[15] = '{8'h01, 1'b1, 1'b1, 8'h01, 3'd0, 1'b1};
        tbl[16] = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};

        // Reset state, then the directed table.
        do_reset();
        @(negedge clk);
        chk("rst_valid", valid, 1'b0);
        chk("rst_sel",   s,     3'd0);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_y",     y,     8'hA3);
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            req   = tbl[i].req;
            ready = tbl[i].rdy;
            @(negedge clk);
            chk("tbl_valid", valid, tbl[i].ev);
            chk("tbl_ack",   ack,   tbl[i].eack);
            chk("tbl_sel",   s,     tbl[i].es);
            chk("tbl_busy",  busy,  tbl[i].eb);
            chk("tbl_y",     y,     8'hA3 + 8'(tbl[i].es));
            check_model();
            @(posedge clk);
            model_update();
            #1;
        end

        // Full load: ack walks 01..80 and wraps without idle cycles.
        do_reset();
        req   = 8'hFF;
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("full_ack", ack, (i == 0) ? 8'h00 : (8'h01 << ((i - 1) % 8)));
            check_model();
            @(posedge clk);
            model_update();
            #1;
        end

        // Asynchronous reset in the middle of a stalled grant.
        ready = 1'b0;
        cycle();
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk("amid_valid", valid, 1'b0);
        chk("amid_sel",   s,     3'd0);
        chk("amid_busy",  busy,  1'b0);
        chk("amid_ack",   ack,   8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 8'h03;
        cycle();
        @(negedge clk);
        chk("post_rst_sel",   s,     3'd0);
        chk("post_rst_valid", valid, 1'b1);
        @(posedge clk);
        model_update();
        #1;

`ifdef MUX_ARB_LOCK_EN
        do_reset();
        req   = 8'h18;
        lock  = 8'h08;
        ready = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lock_ack", ack, 8'h08);
            check_model();
            @(posedge clk);
            model_update();
            #1;
        end
        lock = 8'h00;
        @(negedge clk);
        chk("unlock_ack", ack, 8'h08);
        @(posedge clk);
        model_update();
        #1;
        @(negedge clk);
        chk("after_lock_ack", ack, 8'h10);
        chk("after_lock_sel", s,   3'd4);
        @(posedge clk);
        model_update();
        #1;
`endif

        // Randomized traffic with re-requests, withdrawals and backpressure.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] eack;
            eack = m_ack();
            cycle();
            for (int k = 0; k < N; k++) begin
                if (eack[k])     req[k] = 1'($urandom % 2);
                else if (req[k]) begin
                    if ($urandom % 16 == 0) req[k] = 1'b0;
                end else if ($urandom % 3 == 0) req[k] = 1'b1;
                if (!req[k]) a[k*DW +: DW] = 8'($urandom);
            end
            ready = ($urandom % 4) != 0;
`ifdef MUX_ARB_LOCK_EN
            lock = 8'($urandom) & 8'($urandom);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
